// File: rtl/simon_pkg.sv
// simon_pkg: shared definitions for the Simon game controller.
//   state_t      - FSM codes, also decoded by the text-display stage
//   LFSR_SEED    - value loaded into the colour LFSR on reset
//   LFSR_TAPS    - feedback mask for the colour LFSR
//   onehot()     - 2-bit colour to 4-bit lamp/button mask
//   max_of4()    - widest of four cycle counts, sizes the phase counter
package simon_pkg;

  typedef enum logic [2:0] {
    ST_READY  = 3'd0,
    ST_SIMON  = 3'd1,
    ST_USER   = 3'd2,
    ST_RESULT = 3'd3,
    ST_WIN    = 3'd4,
    ST_FILL   = 3'd5
  } state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // x^16+x^14+x^13+x^11+1 in right-shifting Fibonacci form: taps at bits 0,2,3,5.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [3:0] onehot(input logic [1:0] c);
    return 4'b0001 << c;
  endfunction

  function automatic int unsigned max_of4(input int unsigned a, input int unsigned b,
                                          input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/simon_game_ctrl_if.sv
// simon_game_ctrl_if: player/display-facing signals of the Simon controller.
//   start - debounced start level (rising edge begins a game)
//   btn   - debounced colour buttons
//   led   - one-hot colour lamp
//   level - current level, 0-based
//   state - FSM code (simon_pkg::state_t values)
//   match - verdict of the most recent press
// master: player/test side; slave: the controller.
interface simon_game_ctrl_if;
  logic       start;
  logic [3:0] btn;
  logic [3:0] led;
  logic [2:0] level;
  logic [2:0] state;
  logic       match;

  modport master (output start, btn, input led, level, state, match);
  modport slave  (input start, btn, output led, level, state, match);
endinterface

// File: rtl/simon_lfsr.sv
// simon_lfsr: free-running 16-bit Fibonacci LFSR supplying colours.
//   clk - clock
//   rst - asynchronous active-high reset, loads LFSR_SEED
//   q   - current LFSR value; shifts every cycle
module simon_lfsr
  import simon_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= LFSR_SEED;
    else     q <= {^(q & LFSR_TAPS), q[15:1]};
  end

endmodule

// File: rtl/simon_game_ctrl.sv
// simon_game_ctrl: Simon game sequencer. Fills a random colour sequence,
// plays it back on the lamps, checks the player's presses and advances or
// resets the level.
//   clk - clock
//   rst - asynchronous active-high reset
//   bus - simon_game_ctrl_if.slave (start, btn in; led, level, state, match out)
//
// state  | meaning
// READY  | idle, waiting for a start edge
// SIMON  | playing back seq[0..level]: lamp lit, then dark gap
// USER   | collecting presses, led mirrors the buttons
// RESULT | verdict held with lamps dark
// WIN    | all levels cleared, level held
// FILL   | writing one LFSR colour per cycle into seq
module simon_game_ctrl
  import simon_pkg::*;
#(
  parameter int unsigned MAX_LEVEL      = 6,
  parameter int unsigned ON_CYCLES      = 25_000_000,
  parameter int unsigned GAP_CYCLES     = 12_500_000,
  parameter int unsigned RESULT_CYCLES  = 50_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 250_000_000
) (
  input  logic             clk,
  input  logic             rst,
  simon_game_ctrl_if.slave bus
);

  localparam int unsigned CNT_W =
    $clog2(max_of4(ON_CYCLES, GAP_CYCLES, RESULT_CYCLES, TIMEOUT_CYCLES) + 1);
  localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] RES_LOAD = CNT_W'(RESULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]       LAST_LVL = 3'(MAX_LEVEL - 1);

  state_t           state_q;
  logic [2:0]       level_q;
  logic [2:0]       idx;
  logic             match_q;
  logic [3:0]       led_q;
  logic [CNT_W-1:0] cnt;
  logic             lit;
  logic [3:0]       btn_q;
  logic             start_q;
  logic [1:0]       seq [MAX_LEVEL];
  logic [15:0]      lfsr;
  logic [3:0]       press;
  logic             go;
  logic [1:0]       first_col;
  logic             unused_lfsr_hi;

  simon_lfsr u_lfsr (.clk(clk), .rst(rst), .q(lfsr));

  assign press          = bus.btn & ~btn_q;
  assign go             = bus.start & ~start_q;
  assign unused_lfsr_hi = ^lfsr[15:2];
  // With a single-step sequence seq[0] is written on the same edge that leaves FILL.
  assign first_col      = (MAX_LEVEL == 1) ? lfsr[1:0] : seq[0];

  assign bus.led   = led_q;
  assign bus.level = level_q;
  assign bus.state = state_q;
  assign bus.match = match_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_READY;
      level_q <= '0;
      idx     <= '0;
      match_q <= 1'b0;
      led_q   <= '0;
      cnt     <= '0;
      lit     <= 1'b0;
      btn_q   <= '0;
      start_q <= 1'b0;
      for (int i = 0; i < MAX_LEVEL; i++) seq[i] <= '0;
    end else begin
      btn_q   <= bus.btn;
      start_q <= bus.start;
      case (state_q)
        ST_READY, ST_WIN: begin
          led_q <= '0;
          if (go) begin
            match_q <= 1'b0;
            level_q <= '0;
            idx     <= '0;
            state_q <= ST_FILL;
          end
        end
        ST_FILL: begin
          seq[idx] <= lfsr[1:0];
          if (idx == LAST_LVL) begin
            state_q <= ST_SIMON;
            idx     <= '0;
            lit     <= 1'b1;
            cnt     <= ON_LOAD;
            led_q   <= onehot(first_col);
          end else begin
            idx <= idx + 3'd1;
          end
        end
        ST_SIMON: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (lit) begin
            lit   <= 1'b0;
            led_q <= '0;
            cnt   <= GAP_LOAD;
          end else if (idx == level_q) begin
            state_q <= ST_USER;
            idx     <= '0;
            cnt     <= TMO_LOAD;
            led_q   <= bus.btn;
          end else begin
            idx   <= idx + 3'd1;
            lit   <= 1'b1;
            cnt   <= ON_LOAD;
            led_q <= onehot(seq[idx + 3'd1]);
          end
        end
        ST_USER: begin
          // led tracks btn_q by registering the same input one cycle on.
          led_q <= bus.btn;
          if (press != '0) begin
            if (press == onehot(seq[idx])) begin
              match_q <= 1'b1;
              if (idx == level_q) begin
                state_q <= ST_RESULT;
                cnt     <= RES_LOAD;
                led_q   <= '0;
              end else begin
                idx <= idx + 3'd1;
                cnt <= TMO_LOAD;
              end
            end else begin
              match_q <= 1'b0;
              state_q <= ST_RESULT;
              cnt     <= RES_LOAD;
              led_q   <= '0;
            end
          end else if (cnt == '0) begin
            match_q <= 1'b0;
            state_q <= ST_RESULT;
            cnt     <= RES_LOAD;
            led_q   <= '0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RESULT: begin
          led_q <= '0;
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (!match_q) begin
            level_q <= '0;
            state_q <= ST_READY;
          end else if (level_q == LAST_LVL) begin
            state_q <= ST_WIN;
          end else begin
            level_q <= level_q + 3'd1;
            state_q <= ST_SIMON;
            idx     <= '0;
            lit     <= 1'b1;
            cnt     <= ON_LOAD;
            led_q   <= onehot(seq[0]);
          end
        end
        default: begin
          state_q <= ST_READY;
          led_q   <= '0;
          idx     <= '0;
          cnt     <= '0;
          lit     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_simon_game_ctrl.sv
// tb_simon_game_ctrl: randomized self-checking bench for simon_game_ctrl.
// Games are played against a rule-level model: colours come from a model
// LFSR, phase lengths and verdicts from the game rules.
module tb_simon_game_ctrl;

  localparam int MAX_LVL = 6;
  localparam int ON      = 4;
  localparam int GAP     = 2;
  localparam int RES     = 3;
  localparam int TMO     = 20;

  localparam logic [2:0] S_READY  = 3'd0;
  localparam logic [2:0] S_SIMON  = 3'd1;
  localparam logic [2:0] S_USER   = 3'd2;
  localparam logic [2:0] S_RESULT = 3'd3;
  localparam logic [2:0] S_WIN    = 3'd4;
  localparam logic [2:0] S_FILL   = 3'd5;

  logic clk = 1'b0;
  logic rst = 1'b0;

  simon_game_ctrl_if bus ();

  simon_game_ctrl #(
    .MAX_LEVEL     (MAX_LVL),
    .ON_CYCLES     (ON),
    .GAP_CYCLES    (GAP),
    .RESULT_CYCLES (RES),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] m_lfsr;
  logic [1:0]  m_seq [MAX_LVL];

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    int unsigned x;
    int unsigned fb;
    x  = v;
    fb = (x ^ (x >> 2) ^ (x >> 3) ^ (x >> 5)) & 1;
    return 16'((x >> 1) | (fb << 15));
  endfunction

  function automatic logic [3:0] oh(input int c);
    return 4'(1 << c);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= lfsr_next(m_lfsr);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic [2:0] st);
    for (int i = 0; i < n; i++) begin
      bus.btn = 4'($urandom_range(0, 15));
      tick();
      chk("idle_state", bus.state, st);
      chk("idle_led", bus.led, 0);
    end
    bus.btn = '0;
  endtask

  task automatic start_game();
    bus.start = 1'b1;
    bus.btn   = 4'($urandom_range(0, 15));
    tick();
    bus.start = 1'b0;
    bus.btn   = '0;
    for (int i = 0; i < MAX_LVL; i++) begin
      chk("fill_state", bus.state, S_FILL);
      chk("fill_level", bus.level, 0);
      chk("fill_match", bus.match, 0);
      m_seq[i] = m_lfsr[1:0];
      tick();
    end
  endtask

  task automatic play(input int lvl, input logic [3:0] held);
    for (int s = 0; s <= lvl; s++) begin
      chk("simon_level", bus.level, lvl);
      for (int k = 0; k < ON; k++) begin
        chk("simon_state", bus.state, S_SIMON);
        chk("simon_led_on", bus.led, oh(m_seq[s]));
        bus.btn = 4'($urandom_range(0, 15));
        tick();
      end
      for (int k = 0; k < GAP; k++) begin
        chk("simon_state", bus.state, S_SIMON);
        chk("simon_led_gap", bus.led, 0);
        if (s == lvl && k == GAP - 1) bus.btn = held;
        else                          bus.btn = 4'($urandom_range(0, 15));
        tick();
      end
    end
  endtask

  // mode: 0 correct, 1 wrong colour, 2 two bits together, 3 timeout
  task automatic user_phase(input int lvl, input int mode, input logic [3:0] held,
                            output bit verdict);
    int since;
    int bad_step;
    logic [3:0] c;
    since    = 0;
    bad_step = $urandom_range(0, lvl);
    chk("user_entry_state", bus.state, S_USER);
    chk("user_entry_led", bus.led, held);
    for (int s = 0; s <= lvl; s++) begin
      if (s == 0 && held != '0) begin
        tick(); since++;
        chk("held_no_press", bus.state, S_USER);
      end
      if (s > 0 || held != '0) begin
        bus.btn = '0;
        tick(); since++;
        chk("user_wait", bus.state, S_USER);
      end
      repeat ($urandom_range(0, 3)) begin
        tick(); since++;
        chk("user_wait", bus.state, S_USER);
      end
      if (mode == 3 && s == bad_step) begin
        while (since < TMO) begin
          chk("user_wait", bus.state, S_USER);
          tick(); since++;
        end
        chk("timeout_state", bus.state, S_RESULT);
        chk("timeout_match", bus.match, 0);
        verdict = 1'b0;
        return;
      end
      c = oh(m_seq[s]);
      if (mode == 1 && s == bad_step)
        bus.btn = oh((m_seq[s] + 1 + $urandom_range(0, 2)) % 4);
      else if (mode == 2 && s == bad_step)
        bus.btn = c | oh((m_seq[s] + 1 + $urandom_range(0, 2)) % 4);
      else
        bus.btn = c;
      tick(); since = 0;
      if ((mode == 1 || mode == 2) && s == bad_step) begin
        chk("bad_match", bus.match, 0);
        chk("bad_state", bus.state, S_RESULT);
        verdict = 1'b0;
        return;
      end
      chk("good_match", bus.match, 1);
      if (s == lvl) begin
        chk("last_press_state", bus.state, S_RESULT);
      end else begin
        chk("next_press_state", bus.state, S_USER);
        chk("user_led", bus.led, c);
      end
    end
    verdict = 1'b1;
  endtask

  task automatic result_phase(input bit verdict, input int lvl);
    for (int k = 0; k < RES; k++) begin
      chk("result_state", bus.state, S_RESULT);
      chk("result_led", bus.led, 0);
      chk("result_match", bus.match, verdict);
      chk("result_level", bus.level, lvl);
      bus.btn = 4'($urandom_range(0, 15));
      tick();
    end
    bus.btn = '0;
    if (!verdict) begin
      chk("lose_state", bus.state, S_READY);
      chk("lose_level", bus.level, 0);
    end else if (lvl == MAX_LVL - 1) begin
      chk("win_state", bus.state, S_WIN);
      chk("win_level", bus.level, lvl);
    end else begin
      chk("advance_state", bus.state, S_SIMON);
      chk("advance_level", bus.level, lvl + 1);
    end
  endtask

  task automatic mid_reset();
    repeat (3) begin
      bus.btn = 4'($urandom_range(0, 15));
      tick();
    end
    bus.btn = '0;
    #1 rst = 1'b1;
    #1;
    chk("rst_state", bus.state, S_READY);
    chk("rst_level", bus.level, 0);
    chk("rst_match", bus.match, 0);
    chk("rst_led", bus.led, 0);
    tick();
    tick();
    rst = 1'b0;
    idle(2, S_READY);
  endtask

  task automatic run_game(input int fail_lvl, input int fail_mode, input int abort_lvl);
    bit verdict;
    logic [3:0] held;
    start_game();
    for (int lvl = 0; lvl < MAX_LVL; lvl++) begin
      if (lvl == abort_lvl) begin
        mid_reset();
        return;
      end
      held = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      play(lvl, held);
      user_phase(lvl, (lvl == fail_lvl) ? fail_mode : 0, held, verdict);
      result_phase(verdict, lvl);
      if (!verdict) return;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int fl;
    bus.start = 1'b0;
    bus.btn   = '0;
    #1 rst = 1'b1;
    #1;
    chk("reset_state", bus.state, S_READY);
    chk("reset_level", bus.level, 0);
    chk("reset_match", bus.match, 0);
    chk("reset_led", bus.led, 0);
    tick();
    rst = 1'b0;
    idle(3, S_READY);

    run_game(-1, 0, -1);
    idle(3, S_WIN);
    run_game(0, 1, -1);
    idle(2, S_READY);
    run_game(1, 3, -1);
    run_game(2, 2, -1);
    run_game(-1, 0, 2);
    run_game(0, 3, -1);

    for (int g = 0; g < 6; g++) begin
      fl = $urandom_range(0, MAX_LVL);
      run_game(fl, $urandom_range(1, 3), -1);
      idle($urandom_range(1, 3), (fl >= MAX_LVL) ? S_WIN : S_READY);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
